// File: rtl/cpu_pkg.sv
// cpu_pkg: shared types and default widths for the ACU memory-bus slice.
//   CPU_AW / CPU_DW / CPU_TIMEOUT : default address width, data width and
//                                   wait-state limit for acu_bus
//   bus_state_t                   : acu_bus FSM state encoding (2 bits)
//   bus_op_t                      : latched operation type of a burst
package cpu_pkg;

  localparam int CPU_AW      = 16;
  localparam int CPU_DW      = 8;
  localparam int CPU_TIMEOUT = 15;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    DONE   = 2'd3
  } bus_state_t;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } bus_op_t;

endpackage

// File: rtl/acu_bus_wdog.sv
// acu_bus_wdog: wait-state / timeout counter for one bus access.
//   clk, rst : clock, synchronous active-low reset (count clears to 0)
//   clr      : reload the counter for a fresh access (TIMEOUT-1 remaining)
//   en       : count one wait cycle
//   expired  : the current wait cycle is the TIMEOUT-th without ready
// Implemented as a down-counter: loaded with TIMEOUT-1 and compared
// against zero, so 'expired' is true in the TIMEOUT-th waiting cycle.
module acu_bus_wdog #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [7:0] LOAD = 8'(TIMEOUT - 1);

  logic [7:0] count;

  always_ff @(posedge clk) begin
    if (!rst) begin
      count <= 8'd0;
    end else if (clr) begin
      count <= LOAD;
    end else if (en && count != 8'd0) begin
      count <= count - 8'd1;
    end
  end

  assign expired = (count == 8'd0);

endmodule

// File: rtl/acu_bus.sv
// acu_bus: turns the ACU address into byte-wide read/write bursts on the
// external memory bus, with ready handshake, wait states, per-beat address
// increment and timeout abort.
//   clk, rst          : clock, synchronous active-low reset
//   addr, addr_vld    : burst start address from the ACU and its enable
//   req_rd, req_wr    : request levels, sampled only in IDLE
//   len               : beats minus one, latched at accept
//   wdata, wr_take    : write byte, taken in the cycle wr_take is high
//   rdata, rdata_vld  : last read byte and its one-cycle valid pulse
//   busy, done, err   : status (not idle / burst complete / illegal or timeout)
//   mem_addr/dout/din : memory bus address, write data, read data
//   mem_rd, mem_wr    : bus strobes, high throughout ACCESS
//   mem_rdy           : memory ready
//
//   state  | meaning
//   IDLE   | waiting for a legal request with addr_vld
//   SETUP  | address stable, strobes low, write byte taken
//   ACCESS | strobe high, waiting for mem_rdy or timeout
//   DONE   | one-cycle done pulse, then back to IDLE
module acu_bus
  import cpu_pkg::*;
#(
  parameter int AW      = CPU_AW,
  parameter int DW      = CPU_DW,
  parameter int TIMEOUT = CPU_TIMEOUT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] addr,
  input  logic          addr_vld,
  input  logic          req_rd,
  input  logic          req_wr,
  input  logic [3:0]    len,
  input  logic [DW-1:0] wdata,
  output logic          wr_take,
  output logic [DW-1:0] rdata,
  output logic          rdata_vld,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_dout,
  input  logic [DW-1:0] mem_din,
  output logic          mem_rd,
  output logic          mem_wr,
  input  logic          mem_rdy
);

  bus_state_t state;
  bus_op_t    op;
  logic [3:0] beats;
  logic       wd_expired;

  acu_bus_wdog #(.TIMEOUT(TIMEOUT)) u_wdog (
    .clk     (clk),
    .rst     (rst),
    .clr     (state == SETUP),
    .en      (state == ACCESS && !mem_rdy),
    .expired (wd_expired)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      op        <= OP_RD;
      beats     <= 4'd0;
      wr_take   <= 1'b0;
      rdata     <= '0;
      rdata_vld <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      mem_addr  <= '0;
      mem_dout  <= '0;
      mem_rd    <= 1'b0;
      mem_wr    <= 1'b0;
    end else begin
      // pulse outputs default low
      wr_take   <= 1'b0;
      rdata_vld <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      case (state)
        IDLE: begin
          if (addr_vld && (req_rd ^ req_wr)) begin
            mem_addr <= addr;
            beats    <= len;
            op       <= req_wr ? OP_WR : OP_RD;
            wr_take  <= req_wr;
            busy     <= 1'b1;
            state    <= SETUP;
          end else if (addr_vld && req_rd && req_wr) begin
            err <= 1'b1;
          end
        end
        SETUP: begin
          if (op == OP_WR) mem_dout <= wdata;
          mem_rd <= (op == OP_RD);
          mem_wr <= (op == OP_WR);
          state  <= ACCESS;
        end
        ACCESS: begin
          // ready takes priority over a coincident timeout
          if (mem_rdy) begin
            mem_rd <= 1'b0;
            mem_wr <= 1'b0;
            if (op == OP_RD) begin
              rdata     <= mem_din;
              rdata_vld <= 1'b1;
            end
            if (beats == 4'd0) begin
              done  <= 1'b1;
              state <= DONE;
            end else begin
              beats    <= beats - 4'd1;
              mem_addr <= mem_addr + AW'(1);
              wr_take  <= (op == OP_WR);
              state    <= SETUP;
            end
          end else if (wd_expired) begin
            mem_rd <= 1'b0;
            mem_wr <= 1'b0;
            err    <= 1'b1;
            busy   <= 1'b0;
            state  <= IDLE;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_acu_bus.sv
// tb_acu_bus: directed self-checking bench for acu_bus. Inputs change #1
// after a rising edge; outputs are sampled at that same point.
module tb_acu_bus;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] addr;
  logic        addr_vld, req_rd, req_wr;
  logic [3:0]  len;
  logic [7:0]  wdata;
  logic        wr_take;
  logic [7:0]  rdata;
  logic        rdata_vld, busy, done, err;
  logic [15:0] mem_addr;
  logic [7:0]  mem_dout, mem_din;
  logic        mem_rd, mem_wr, mem_rdy;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  acu_bus dut (
    .clk(clk), .rst(rst), .addr(addr), .addr_vld(addr_vld),
    .req_rd(req_rd), .req_wr(req_wr), .len(len), .wdata(wdata),
    .wr_take(wr_take), .rdata(rdata), .rdata_vld(rdata_vld), .busy(busy),
    .done(done), .err(err), .mem_addr(mem_addr), .mem_dout(mem_dout),
    .mem_din(mem_din), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_rdy(mem_rdy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic req(input logic [15:0] a, input logic rd, input logic wr, input logic [3:0] l);
    addr = a; req_rd = rd; req_wr = wr; len = l; addr_vld = 1'b1;
  endtask

  task automatic unreq();
    addr_vld = 1'b0; req_rd = 1'b0; req_wr = 1'b0;
  endtask

  logic [7:0] wbytes [3];
  int  cyc;
  logic seen;

  initial begin
    wbytes[0] = 8'h11; wbytes[1] = 8'h22; wbytes[2] = 8'h33;
    rst = 1'b0; addr = '0; addr_vld = 0; req_rd = 0; req_wr = 0; len = '0;
    wdata = '0; mem_din = '0; mem_rdy = 0;

    // reset state
    tick(); tick();
    chk("rst_busy", busy, 0);
    chk("rst_outs", {mem_rd, mem_wr, done, err, rdata_vld, wr_take}, 0);
    chk("rst_addr", mem_addr, 16'h0000);
    chk("rst_data", {rdata, mem_dout}, 16'h0000);
    rst = 1'b1;
    tick();

    // single zero-wait read
    req(16'h4064, 1, 0, 4'd0); mem_rdy = 1; mem_din = 8'hA5;
    tick(); unreq();                               // E0
    chk("rd_e0_busy", busy, 1);
    chk("rd_e0_addr", mem_addr, 16'h4064);
    chk("rd_e0_strb", {mem_rd, wr_take}, 0);
    tick();                                        // E1
    chk("rd_e1_mem_rd", mem_rd, 1);
    chk("rd_e1_addr", mem_addr, 16'h4064);
    tick();                                        // E2
    chk("rd_e2_mem_rd", mem_rd, 0);
    chk("rd_e2_rdata", rdata, 8'hA5);
    chk("rd_e2_vld_done", {rdata_vld, done, busy}, 3'b111);
    tick();                                        // E3
    chk("rd_e3_idle", {busy, done, rdata_vld}, 0);
    chk("rd_e3_hold", rdata, 8'hA5);

    // three-beat write, two wait states per beat
    mem_rdy = 0; wdata = wbytes[0];
    req(16'h2000, 0, 1, 4'd2);
    tick(); unreq(); cyc = 0;                      // accept
    chk("wr_take0", {wr_take, busy}, 2'b11);
    chk("wr_addr0", mem_addr, 16'h2000);
    for (int b = 0; b < 3; b++) begin
      tick(); cyc++;
      chk($sformatf("wr%0d_strobe", b), {mem_wr, mem_rd, wr_take}, 3'b100);
      chk($sformatf("wr%0d_dout", b), mem_dout, wbytes[b]);
      chk($sformatf("wr%0d_addr", b), mem_addr, 16'h2000 + 16'(b));
      tick(); cyc++;
      chk($sformatf("wr%0d_wait1", b), mem_wr, 1);
      tick(); cyc++;
      chk($sformatf("wr%0d_wait2", b), mem_wr, 1);
      mem_rdy = 1;
      tick(); cyc++;
      mem_rdy = 0;
      if (b < 2) begin
        chk($sformatf("wr%0d_next", b), {wr_take, mem_wr, done}, 3'b100);
        chk($sformatf("wr%0d_inc", b), mem_addr, 16'h2001 + 16'(b));
        wdata = wbytes[b + 1];
      end else begin
        chk("wr_done", {done, mem_wr, rdata_vld}, 3'b100);
        chk("wr_done_cyc", cyc, 12);
      end
    end
    tick();
    chk("wr_idle", busy, 0);

    // read wrapping 0xFFFF -> 0x0000
    req(16'hFFFF, 1, 0, 4'd1); mem_rdy = 1; mem_din = 8'h3C;
    tick(); unreq();
    chk("wrap_addr0", mem_addr, 16'hFFFF);
    tick();
    chk("wrap_rd0", {mem_rd, mem_addr}, {1'b1, 16'hFFFF});
    tick(); mem_din = 8'hC3;
    chk("wrap_beat0", {rdata_vld, done, mem_rd, rdata}, {3'b100, 8'h3C});
    chk("wrap_addr1", mem_addr, 16'h0000);
    tick();
    chk("wrap_rd1", {mem_rd, mem_addr}, {1'b1, 16'h0000});
    tick();
    chk("wrap_done", {rdata_vld, done, rdata}, {2'b11, 8'hC3});
    tick();
    chk("wrap_idle", busy, 0);

    // timeout: mem_rdy never asserted
    mem_rdy = 0;
    req(16'h1234, 1, 0, 4'd0);
    tick(); unreq();
    seen = 0;
    for (int i = 1; i <= 15; i++) begin
      tick();
      seen = seen | done | rdata_vld | err | !busy | !mem_rd;
    end
    chk("to_waiting", seen, 0);
    tick();
    chk("to_err", {err, busy, mem_rd, done, rdata_vld}, 5'b10000);
    tick();
    chk("to_after", {err, busy}, 0);

    // illegal request and addr_vld gating
    req(16'h0042, 1, 1, 4'd0);
    tick(); unreq();
    chk("ill_err", {err, busy}, 2'b10);
    tick();
    chk("ill_clear", {err, busy}, 0);
    req(16'h0042, 1, 0, 4'd0); addr_vld = 0;
    tick(); tick();
    chk("gate_idle", {err, busy, mem_rd, wr_take}, 0);
    unreq();

    // reset in the middle of a four-beat read
    req(16'h5555, 1, 0, 4'd3);
    tick(); unreq();
    tick(); tick();
    chk("mid_access", mem_rd, 1);
    rst = 0;
    tick();
    chk("mid_rst_strb", {mem_rd, mem_wr, busy, done, err}, 0);
    chk("mid_rst_addr", {mem_addr, rdata}, 24'h0);
    rst = 1;
    tick();
    chk("mid_rst_quiet", {done, err, busy}, 0);
    req(16'h0100, 1, 0, 4'd0); mem_rdy = 1; mem_din = 8'h5A;
    tick(); unreq();
    chk("post_accept", {busy, mem_addr}, {1'b1, 16'h0100});
    tick();
    chk("post_rd", mem_rd, 1);
    tick();
    chk("post_done", {done, rdata_vld, rdata}, {2'b11, 8'h5A});
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
